// File: rtl/branch_resolve_bht.sv
// Branch resolution unit: evaluates RISC-V conditional branches, keeps a BHT of
// 2-bit saturating counters for fetch prediction, and counts branches/mispredicts.
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         IDX_LSB     = 2,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  rv1,
  input  logic [XLEN-1:0]  rv2,
  input  logic [2:0]       func3,
  input  logic             res_pred_taken,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [BHT_ENTRIES-1:0][1:0] bht_q;
  logic [IDX_W-1:0]            pred_idx, res_idx;
  logic                        legal, taken, upd, mis;
  logic [1:0]                  ctr_cur, ctr_d;
  logic                        out_valid_q, out_taken_q, out_mis_q, out_ill_q;
  logic [CNT_W-1:0]            br_count_q, mp_count_q;
  logic                        unused_pc_bits;

  assign pred_idx = pred_pc[IDX_LSB +: IDX_W];
  assign res_idx  = res_pc[IDX_LSB +: IDX_W];
  assign unused_pc_bits = ^{pred_pc, res_pc};

  // 010/011 are the only reserved branch encodings
  assign legal = (func3[2:1] != 2'b01);

  always_comb begin
    taken = 1'b0;
    unique case (func3)
      3'b000:  taken = (rv1 == rv2);
      3'b001:  taken = (rv1 != rv2);
      3'b100:  taken = ($signed(rv1) <  $signed(rv2));
      3'b101:  taken = ($signed(rv1) >= $signed(rv2));
      3'b110:  taken = (rv1 <  rv2);
      3'b111:  taken = (rv1 >= rv2);
      default: taken = 1'b0;
    endcase
  end

  assign upd = res_valid & legal;
  assign mis = taken != res_pred_taken;

  always_comb begin
    ctr_cur = bht_q[res_idx];
    ctr_d   = ctr_cur;
    if (taken && ctr_cur != 2'b11)       ctr_d = ctr_cur + 2'd1;
    else if (!taken && ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
  end

  // Read-before-write: prediction sees the state from before this edge's update
  assign pred_taken = bht_q[pred_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
    end else if (upd) begin
      bht_q[res_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      out_mis_q   <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      out_valid_q <= res_valid;
      out_taken_q <= upd & taken;
      out_mis_q   <= upd & mis;
      out_ill_q   <= res_valid & ~legal;
    end
  end

  // Clear wins over a concurrent increment; counters stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (stat_clr) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (upd) begin
      if (br_count_q != '1)        br_count_q <= br_count_q + CNT_W'(1);
      if (mis && mp_count_q != '1) mp_count_q <= mp_count_q + CNT_W'(1);
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_mispredict = out_mis_q;
  assign out_illegal    = out_ill_q;
  assign br_count       = br_count_q;
  assign mp_count       = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: a default instance plus a CNT_W=4
// instance used for counter saturation.
module tb_branch_resolve_bht;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pred_pc, res_pc, rv1, rv2;
  logic [2:0]  func3;
  logic        res_valid, res_pred_taken, stat_clr;
  logic        pred_taken, out_valid, out_taken, out_mispredict, out_illegal;
  logic [31:0] br_count, mp_count;

  logic [31:0] b_pred_pc, b_res_pc, b_rv1, b_rv2;
  logic [2:0]  b_func3;
  logic        b_res_valid, b_res_pred_taken, b_stat_clr;
  logic        b_pred_taken, b_out_valid, b_out_taken, b_out_mispredict, b_out_illegal;
  logic [3:0]  b_br_count, b_mp_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_bht dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .rv1(rv1), .rv2(rv2), .func3(func3),
    .res_pred_taken(res_pred_taken), .out_valid(out_valid), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal), .stat_clr(stat_clr),
    .br_count(br_count), .mp_count(mp_count)
  );

  branch_resolve_bht #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .pred_pc(b_pred_pc), .pred_taken(b_pred_taken),
    .res_valid(b_res_valid), .res_pc(b_res_pc), .rv1(b_rv1), .rv2(b_rv2), .func3(b_func3),
    .res_pred_taken(b_res_pred_taken), .out_valid(b_out_valid), .out_taken(b_out_taken),
    .out_mispredict(b_out_mispredict), .out_illegal(b_out_illegal), .stat_clr(b_stat_clr),
    .br_count(b_br_count), .mp_count(b_mp_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] sw_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic       sw_tk [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    pred_pc = 32'h100; res_pc = '0; rv1 = '0; rv2 = '0; func3 = '0;
    res_valid = 1'b0; res_pred_taken = 1'b0; stat_clr = 1'b0;
    b_pred_pc = '0; b_res_pc = 32'h0; b_rv1 = '0; b_rv2 = '0; b_func3 = '0;
    b_res_valid = 1'b0; b_res_pred_taken = 1'b0; b_stat_clr = 1'b0;
    #12;
    chk("rst_pred", 32'(pred_taken), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_taken", 32'(out_taken), 0);
    chk("rst_mis", 32'(out_mispredict), 0);
    chk("rst_ill", 32'(out_illegal), 0);
    chk("rst_br", br_count, 0);
    chk("rst_mp", mp_count, 0);
    rst_n = 1'b1;
    tick;

    // func3 sweep: -1 vs 1, predicted not-taken; index 0 via pc 0x200
    rv1 = 32'hFFFF_FFFF; rv2 = 32'h1; res_pc = 32'h200; res_pred_taken = 1'b0;
    res_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      func3 = sw_f3[i];
      tick;
      chk($sformatf("sw%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("sw%0d_taken", i), 32'(out_taken), 32'(sw_tk[i]));
      chk($sformatf("sw%0d_mis", i), 32'(out_mispredict), 32'(sw_tk[i]));
    end
    res_valid = 1'b0;
    tick;
    chk("sw_idle_valid", 32'(out_valid), 0);
    chk("sw_idle_taken", 32'(out_taken), 0);
    chk("sw_br", br_count, 6);
    chk("sw_mp", mp_count, 3);

    // Train pc 0x40: T,T,T then N,N -> 10,11,11,10,01
    pred_pc = 32'h40; res_pc = 32'h40; func3 = 3'b000; rv1 = 32'd5; rv2 = 32'd5;
    #1 chk("tr_pre", 32'(pred_taken), 0);
    res_valid = 1'b1;
    tick; chk("tr_t1", 32'(pred_taken), 1);
    tick; chk("tr_t2", 32'(pred_taken), 1);
    tick; chk("tr_t3", 32'(pred_taken), 1);
    rv2 = 32'd6;
    tick; chk("tr_n1", 32'(pred_taken), 1);
    chk("tr_n1_mis", 32'(out_mispredict), 0);
    tick; chk("tr_n2", 32'(pred_taken), 0);
    res_valid = 1'b0;
    tick;
    chk("tr_br", br_count, 11);
    chk("tr_mp", mp_count, 6);

    // Same-index collision: read sees pre-update value
    pred_pc = 32'h80; res_pc = 32'h80; rv2 = 32'd5; res_valid = 1'b1;
    #1 chk("col_same", 32'(pred_taken), 0);
    tick;
    res_valid = 1'b0;
    chk("col_next", 32'(pred_taken), 1);

    // Illegal func3: no count, no BHT change, no mispredict
    func3 = 3'b010; res_pred_taken = 1'b1; rv2 = 32'd6; res_valid = 1'b1;
    tick;
    res_valid = 1'b0;
    chk("ill_valid", 32'(out_valid), 1);
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_taken", 32'(out_taken), 0);
    chk("ill_mis", 32'(out_mispredict), 0);
    chk("ill_br", br_count, 12);
    chk("ill_mp", mp_count, 7);
    chk("ill_bht", 32'(pred_taken), 1);
    tick;
    chk("ill_clear", 32'(out_illegal), 0);

    // stat_clr beats a concurrent legal mispredict
    func3 = 3'b000; rv2 = 32'd5; res_pred_taken = 1'b0; res_valid = 1'b1; stat_clr = 1'b1;
    tick;
    res_valid = 1'b0; stat_clr = 1'b0;
    chk("clr_br", br_count, 0);
    chk("clr_mp", mp_count, 0);
    chk("clr_out_mis", 32'(out_mispredict), 1);
    chk("clr_bht", 32'(pred_taken), 1);

    // Async reset while a result is on the outputs
    res_valid = 1'b1;
    tick;
    res_valid = 1'b0;
    chk("ar_pending", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_taken", 32'(out_taken), 0);
    chk("ar_pred", 32'(pred_taken), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("ar_post_pred", 32'(pred_taken), 0);
    chk("ar_post_valid", 32'(out_valid), 0);

    // CNT_W=4: 16 mispredicts saturate at 15
    b_res_pc = 32'h40; b_func3 = 3'b000; b_rv1 = 32'd9; b_rv2 = 32'd9;
    b_res_pred_taken = 1'b0; b_res_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick;
    chk("sat_mp15", 32'(b_mp_count), 15);
    tick;
    chk("sat_mp16", 32'(b_mp_count), 15);
    chk("sat_br16", 32'(b_br_count), 15);
    b_stat_clr = 1'b1;
    tick;
    b_stat_clr = 1'b0; b_res_valid = 1'b0;
    chk("sat_clr_br", 32'(b_br_count), 0);
    chk("sat_clr_mp", 32'(b_mp_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised branch resolution unit for the next-generation core.
- Resolves RISC-V conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) for any XLEN, with a one-cycle registered result.
- Adds a BHT of 2-bit saturating counters for fetch-time prediction, misprediction detection and saturating performance counters.
- Sits between fetch (prediction port) and execute (resolution port).

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.
- IDX_LSB, 2, lowest PC bit used for the BHT index. Index = pc[IDX_LSB +: log2(BHT_ENTRIES)].
- CTR_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  combinational prediction = bht[idx(pred_pc)][1].
- res_valid  in  1  resolution request valid this cycle.
- res_pc  in  XLEN  PC of the branch being resolved.
- rv1, rv2  in  XLEN  branch operands.
- func3  in  3  branch condition code.
- res_pred_taken  in  1  prediction the branch was fetched with.
- out_valid  out  1  registered: a resolution completed.
- out_taken  out  1  registered actual outcome.
- out_mispredict  out  1  registered: out_taken != the res_pred_taken that was captured.
- out_illegal  out  1  registered: func3 was 010 or 011.
- stat_clr  in  1  synchronous clear of the performance counters.
- br_count  out  CNT_W  legal branches resolved.
- mp_count  out  CNT_W  mispredictions.

Behaviour:
- Condition evaluation (combinational, internal):
  - 000: eq. 001: ne.
  - 100: signed lt. 101: signed ge.
  - 110: unsigned lt. 111: unsigned ge.
  - 010/011: illegal; outcome forced to 0.
  - Full XLEN comparison, no truncation.
- Latency: inputs sampled at edge N appear on the out_* signals after edge N; they are valid for exactly one cycle.
- out_valid = previous-cycle res_valid. out_taken, out_mispredict and out_illegal are 0 whenever out_valid is 0.
- Illegal request:
  - out_valid = 1, out_illegal = 1, out_taken = 0, out_mispredict = 0.
  - No BHT update, no counter increment.
- Legal request:
  - BHT update at the same edge: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00.
  - br_count += 1.
  - mp_count += 1 if mispredicted.
  - Both counters saturate at 2^CNT_W - 1; they never wrap.
- Prediction read is combinational from current state. If pred_pc and res_pc share an index in the same cycle, pred_taken reflects the pre-update value (read-before-write, no bypass).
- stat_clr has priority over increment: both counters become 0 at that edge, even with a concurrent legal resolution. It does not affect the BHT or the out_* signals.
- Reset (async assert, any time, including mid-resolution):
  - All BHT counters = CTR_INIT.
  - out_valid, out_taken, out_mispredict, out_illegal = 0.
  - br_count = mp_count = 0.
  - Any in-flight result is discarded.
  - pred_taken = CTR_INIT[1] during reset.
- Back-to-back res_valid every cycle is supported at full throughput.
- Two consecutive same-index updates chain: the second uses the state written by the first.
- PC bits outside the index field are ignored; aliasing between branches is permitted.

Test Plan:
- Reset, then pred_pc=0x100 -> pred_taken=0, all outputs 0. Assert rst_n=0 while a res_valid result is pending -> out_valid=0 immediately (async); after release, pred_taken=0.
- func3 sweep with rv1=0xFFFFFFFF, rv2=1, res_pred_taken=0:
  - 000 -> taken 0; 001 -> 1; 100 -> 1 (signed -1<1); 101 -> 0; 110 -> 0; 111 -> 1.
  - Each result appears one cycle later; br_count=6, mp_count=3.
- Train pc=0x40 with three taken resolutions back-to-back -> counter 01->10->11->11; pred_taken(0x40)=1 from the cycle after the first update. Then two not-taken -> counter 01, pred_taken=0.
- Same-index collision: counter=01, res_pc=pred_pc=0x80 with a taken resolution in the same cycle -> pred_taken=0 that cycle, 1 the next cycle.
- func3=010 with res_valid=1, res_pred_taken=1 -> out_illegal=1, out_mispredict=0, br_count and BHT unchanged.
- CNT_W=4: 16 mispredicted branches -> mp_count stays at 15 (saturated). stat_clr asserted with a concurrent legal mispredict -> both counters read 0 next cycle.
